// File: rtl/aurora_link_watchdog.sv
// Upstream supervisor for the Aurora reset sequencer: it fires reset sequences,
// tracks reset_busy, filters channel_up drops and keeps link health counters.
module aurora_link_watchdog #(
  parameter int unsigned UP_TIMEOUT    = 50000000,
  parameter int unsigned DOWN_FILTER   = 1000,
  parameter int unsigned PULSE_LEN     = 16,
  parameter int unsigned BUSY_TIMEOUT  = 256,
  parameter bit          STARTUP_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        channel_up,
  input  logic        reset_busy,
  input  logic        force_reset,
  output logic        reset_out,
  output logic        link_ok,
  output logic [7:0]  retry_count,
  output logic [15:0] link_drops,
  output logic        busy_fault
);

  typedef enum logic [2:0] {
    S_FIRE,
    S_WAIT_BUSY_HI,
    S_WAIT_BUSY_LO,
    S_WAIT_UP,
    S_UP,
    S_FILTER
  } state_t;

  localparam logic [31:0] LP_PULSE = 32'(PULSE_LEN - 1);
  localparam logic [31:0] LP_BUSY  = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] LP_UP    = 32'(UP_TIMEOUT - 1);
  localparam logic [31:0] LP_DOWN  = 32'(DOWN_FILTER - 1);

  localparam state_t      LP_RST_STATE = STARTUP_RESET ? S_FIRE : S_WAIT_UP;
  // Starting in WAIT_UP counts as entering it, so the up timeout is preloaded.
  localparam logic [31:0] LP_RST_CNT   = STARTUP_RESET ? 32'd0 : LP_UP;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_reset_out;
  logic        r_link_ok;
  logic [7:0]  r_retry;
  logic [15:0] r_drops;
  logic        r_fault;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic        w_reset_out_nxt;
  logic        w_link_ok_nxt;
  logic [7:0]  w_retry_nxt;
  logic [15:0] w_drops_nxt;
  logic        w_fault_nxt;
  logic        w_fire;
  logic        w_drop;
  logic [7:0]  w_retry_sat;
  logic [15:0] w_drops_sat;

  assign w_retry_sat = (r_retry == '1) ? r_retry : r_retry + 8'd1;
  assign w_drops_sat = (r_drops == '1) ? r_drops : r_drops + 16'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = (r_cnt != '0) ? r_cnt - 32'd1 : r_cnt;
    w_reset_out_nxt = r_reset_out;
    w_link_ok_nxt   = r_link_ok;
    w_retry_nxt     = r_retry;
    w_drops_nxt     = r_drops;
    w_fault_nxt     = r_fault;
    w_fire          = 1'b0;
    w_drop          = 1'b0;

    case (r_state)
      S_FIRE: begin
        // Reset leaves FIRE with reset_out low; the first cycle out of reset starts the pulse.
        if (!r_reset_out) begin
          w_reset_out_nxt = 1'b1;
          w_cnt_nxt       = LP_PULSE;
        end else if (r_cnt == '0) begin
          w_reset_out_nxt = 1'b0;
          w_cnt_nxt       = LP_BUSY;
          w_state_nxt     = S_WAIT_BUSY_HI;
        end
      end
      S_WAIT_BUSY_HI: begin
        if (reset_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_BUSY_LO;
        end else if (r_cnt == '0) begin
          w_fault_nxt = 1'b1;
          w_cnt_nxt   = LP_UP;
          w_state_nxt = S_WAIT_UP;
        end
      end
      S_WAIT_BUSY_LO: begin
        if (!reset_busy) begin
          w_cnt_nxt   = LP_UP;
          w_state_nxt = S_WAIT_UP;
        end
      end
      S_WAIT_UP: begin
        if (force_reset) begin
          w_fire = 1'b1;
        end else if (channel_up) begin
          w_link_ok_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_UP;
        end else if (r_cnt == '0) begin
          w_retry_nxt = w_retry_sat;
          w_fire      = 1'b1;
        end
      end
      S_UP: begin
        if (force_reset) begin
          w_fire = 1'b1;
        end else if (!channel_up) begin
          if (DOWN_FILTER == 1) begin
            w_drop = 1'b1;
          end else begin
            w_cnt_nxt   = LP_DOWN;
            w_state_nxt = S_FILTER;
          end
        end
      end
      S_FILTER: begin
        // The first low cycle was spent in UP, so the drop lands when the count hits 1.
        if (force_reset) begin
          w_fire = 1'b1;
        end else if (channel_up) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_UP;
        end else if (r_cnt <= 32'd1) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = LP_RST_STATE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_drop) begin
      w_drops_nxt = w_drops_sat;
      w_fire      = 1'b1;
    end
    if (w_fire) begin
      w_state_nxt     = S_FIRE;
      w_cnt_nxt       = LP_PULSE;
      w_reset_out_nxt = 1'b1;
      w_link_ok_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= LP_RST_STATE;
      r_cnt       <= LP_RST_CNT;
      r_reset_out <= 1'b0;
      r_link_ok   <= 1'b0;
      r_retry     <= '0;
      r_drops     <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_reset_out <= w_reset_out_nxt;
      r_link_ok   <= w_link_ok_nxt;
      r_retry     <= w_retry_nxt;
      r_drops     <= w_drops_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign reset_out   = r_reset_out;
  assign link_ok     = r_link_ok;
  assign retry_count = r_retry;
  assign link_drops  = r_drops;
  assign busy_fault  = r_fault;

endmodule

// File: tb/tb_aurora_link_watchdog.sv
// Directed self-checking bench for aurora_link_watchdog: startup, retries,
// glitch filtering, busy fault, force_reset, mid-pulse reset and saturation.
module tb_aurora_link_watchdog;

  logic        clock;
  logic        reset;
  logic        channel_up;
  logic        reset_busy;
  logic        force_reset;
  logic        reset_out;
  logic        link_ok;
  logic [7:0]  retry_count;
  logic [15:0] link_drops;
  logic        busy_fault;

  int passed = 0;
  int total  = 0;

  aurora_link_watchdog #(
    .UP_TIMEOUT   (100),
    .DOWN_FILTER  (8),
    .PULSE_LEN    (4),
    .BUSY_TIMEOUT (16),
    .STARTUP_RESET(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .channel_up (channel_up),
    .reset_busy (reset_busy),
    .force_reset(force_reset),
    .reset_out  (reset_out),
    .link_ok    (link_ok),
    .retry_count(retry_count),
    .link_drops (link_drops),
    .busy_fault (busy_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called on a negedge where reset_out is high; returns on the first low negedge.
  task automatic finish_pulse(output int width);
    width = 1;
    while (width < 64) begin
      @(negedge clock);
      if (reset_out !== 1'b1) break;
      width++;
    end
  endtask

  task automatic wait_pulse(input int max_wait, output int lat, output int width);
    lat   = -1;
    width = 0;
    for (int i = 1; i <= max_wait; i++) begin
      @(negedge clock);
      if (reset_out === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) finish_pulse(width);
  endtask

  task automatic run_busy(input int n);
    reset_busy = 1'b1;
    repeat (n) @(negedge clock);
    reset_busy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; channel_up = 1'b0; reset_busy = 1'b0; force_reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (reset_out !== 1'b0) $display("FAIL rst_reset_out got %b exp 0", reset_out); else passed++;
    total++; if (link_ok !== 1'b0) $display("FAIL rst_link_ok got %b exp 0", link_ok); else passed++;
    total++; if (retry_count !== 8'd0) $display("FAIL rst_retry got %0d exp 0", retry_count); else passed++;
    total++; if (link_drops !== 16'd0) $display("FAIL rst_drops got %0d exp 0", link_drops); else passed++;
    total++; if (busy_fault !== 1'b0) $display("FAIL rst_busy_fault got %b exp 0", busy_fault); else passed++;
  endtask

  task automatic test_startup;
    int lat, w;
    reset = 1'b0;
    wait_pulse(10, lat, w);
    total++; if (lat !== 1) $display("FAIL startup_latency got %0d exp 1", lat); else passed++;
    total++; if (w !== 4) $display("FAIL startup_width got %0d exp 4", w); else passed++;
    run_busy(20);
    repeat (30) @(negedge clock);
    total++; if (link_ok !== 1'b0) $display("FAIL startup_pre_up got %b exp 0", link_ok); else passed++;
    channel_up = 1'b1;
    @(negedge clock);
    total++; if (link_ok !== 1'b1) $display("FAIL startup_link_ok got %b exp 1", link_ok); else passed++;
    total++; if (retry_count !== 8'd0) $display("FAIL startup_retry got %0d exp 0", retry_count); else passed++;
    total++; if (busy_fault !== 1'b0) $display("FAIL startup_fault got %b exp 0", busy_fault); else passed++;
  endtask

  task automatic test_glitch_filter;
    int seen_pulse = 0;
    int ok_low = 0;
    int w;
    channel_up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (reset_out) seen_pulse = 1;
      if (!link_ok) ok_low = 1;
    end
    channel_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (reset_out) seen_pulse = 1;
      if (!link_ok) ok_low = 1;
    end
    total++; if (seen_pulse !== 0) $display("FAIL glitch_no_pulse got %0d exp 0", seen_pulse); else passed++;
    total++; if (ok_low !== 0) $display("FAIL glitch_link_held got %0d exp 0", ok_low); else passed++;
    total++; if (link_drops !== 16'd0) $display("FAIL glitch_drops got %0d exp 0", link_drops); else passed++;
    channel_up = 1'b0;
    repeat (7) @(negedge clock);
    total++; if (link_ok !== 1'b1) $display("FAIL drop_7low_link got %b exp 1", link_ok); else passed++;
    @(negedge clock);
    total++; if (link_ok !== 1'b0) $display("FAIL drop_8low_link got %b exp 0", link_ok); else passed++;
    total++; if (link_drops !== 16'd1) $display("FAIL drop_count got %0d exp 1", link_drops); else passed++;
    total++; if (reset_out !== 1'b1) $display("FAIL drop_pulse got %b exp 1", reset_out); else passed++;
    finish_pulse(w);
    total++; if (w !== 4) $display("FAIL drop_width got %0d exp 4", w); else passed++;
    channel_up = 1'b1;
    run_busy(5);
    repeat (2) @(negedge clock);
    total++; if (link_ok !== 1'b1) $display("FAIL drop_relink got %b exp 1", link_ok); else passed++;
  endtask

  task automatic test_force_reset;
    int w;
    int seen = 0;
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    total++; if (reset_out !== 1'b1) $display("FAIL force_pulse got %b exp 1", reset_out); else passed++;
    total++; if (link_ok !== 1'b0) $display("FAIL force_link got %b exp 0", link_ok); else passed++;
    total++; if (retry_count !== 8'd0) $display("FAIL force_retry got %0d exp 0", retry_count); else passed++;
    total++; if (link_drops !== 16'd1) $display("FAIL force_drops got %0d exp 1", link_drops); else passed++;
    finish_pulse(w);
    total++; if (w !== 4) $display("FAIL force_width got %0d exp 4", w); else passed++;
    reset_busy = 1'b1;
    repeat (3) @(negedge clock);
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (reset_out) seen = 1;
    end
    reset_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (reset_out) seen = 1;
    end
    total++; if (seen !== 0) $display("FAIL force_ignored_busy got %0d exp 0", seen); else passed++;
    total++; if (link_ok !== 1'b1) $display("FAIL force_relink got %b exp 1", link_ok); else passed++;
  endtask

  task automatic test_no_link;
    int lat, w;
    channel_up  = 1'b0;
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    finish_pulse(w);
    total++; if (w !== 4) $display("FAIL nolink_first_width got %0d exp 4", w); else passed++;
    for (int k = 1; k <= 3; k++) begin
      run_busy(5);
      wait_pulse(200, lat, w);
      total++; if (lat !== 101) $display("FAIL nolink_timeout%0d got %0d exp 101", k, lat); else passed++;
      total++; if (w !== 4) $display("FAIL nolink_width%0d got %0d exp 4", k, w); else passed++;
      total++; if (retry_count !== 8'(k)) $display("FAIL nolink_retry%0d got %0d exp %0d", k, retry_count, k); else passed++;
    end
    run_busy(5);
    channel_up = 1'b1;
    @(negedge clock);
    total++; if (link_ok !== 1'b0) $display("FAIL nolink_pre_up got %b exp 0", link_ok); else passed++;
    @(negedge clock);
    total++; if (link_ok !== 1'b1) $display("FAIL nolink_link_ok got %b exp 1", link_ok); else passed++;
    total++; if (retry_count !== 8'd3) $display("FAIL nolink_retry_final got %0d exp 3", retry_count); else passed++;
  endtask

  task automatic test_busy_fault;
    int w;
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    finish_pulse(w);
    repeat (15) @(negedge clock);
    total++; if (busy_fault !== 1'b0) $display("FAIL fault_early got %b exp 0", busy_fault); else passed++;
    @(negedge clock);
    total++; if (busy_fault !== 1'b1) $display("FAIL fault_at16 got %b exp 1", busy_fault); else passed++;
    total++; if (link_ok !== 1'b0) $display("FAIL fault_link_low got %b exp 0", link_ok); else passed++;
    @(negedge clock);
    total++; if (link_ok !== 1'b1) $display("FAIL fault_wait_up got %b exp 1", link_ok); else passed++;
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    finish_pulse(w);
    run_busy(5);
    repeat (3) @(negedge clock);
    total++; if (busy_fault !== 1'b1) $display("FAIL fault_sticky got %b exp 1", busy_fault); else passed++;
    total++; if (link_ok !== 1'b1) $display("FAIL fault_relink got %b exp 1", link_ok); else passed++;
  endtask

  task automatic test_reset_mid_pulse;
    int lat, w;
    force_reset = 1'b1;
    @(negedge clock);
    force_reset = 1'b0;
    @(negedge clock);
    total++; if (reset_out !== 1'b1) $display("FAIL mid_second_cycle got %b exp 1", reset_out); else passed++;
    reset = 1'b1;
    @(negedge clock);
    total++; if (reset_out !== 1'b0) $display("FAIL mid_truncate got %b exp 0", reset_out); else passed++;
    total++; if (busy_fault !== 1'b0) $display("FAIL mid_fault_clear got %b exp 0", busy_fault); else passed++;
    total++; if (retry_count !== 8'd0) $display("FAIL mid_retry_clear got %0d exp 0", retry_count); else passed++;
    total++; if (link_drops !== 16'd0) $display("FAIL mid_drops_clear got %0d exp 0", link_drops); else passed++;
    reset = 1'b0;
    wait_pulse(5, lat, w);
    total++; if (lat !== 1) $display("FAIL mid_restart_lat got %0d exp 1", lat); else passed++;
    total++; if (w !== 4) $display("FAIL mid_restart_width got %0d exp 4", w); else passed++;
  endtask

  task automatic test_saturation;
    int pulses = 0;
    int at254 = -1;
    int cycles = 0;
    logic prev;
    channel_up = 1'b0;
    reset_busy = 1'b0;
    prev = reset_out;
    while (pulses < 300 && cycles < 40000) begin
      @(negedge clock);
      cycles++;
      if (reset_out && !prev) begin
        pulses++;
        if (pulses == 254) at254 = int'(retry_count);
      end
      prev = reset_out;
    end
    total++; if (pulses !== 300) $display("FAIL sat_pulses got %0d exp 300", pulses); else passed++;
    total++; if (at254 !== 254) $display("FAIL sat_retry254 got %0d exp 254", at254); else passed++;
    total++; if (retry_count !== 8'd255) $display("FAIL sat_retry got %0d exp 255", retry_count); else passed++;
  endtask

  initial begin
    reset = 1'b1; channel_up = 1'b0; reset_busy = 1'b0; force_reset = 1'b0;
    test_reset();
    test_startup();
    test_glitch_filter();
    test_force_reset();
    test_no_link();
    test_busy_fault();
    test_reset_mid_pulse();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
